// File: rtl/control_pkg.sv
// Shared RV32I main-decoder definitions: opcode constants, immediate-format
// encodings and the packed control vector.
package control_pkg;

   localparam int unsigned OPC_W = 7;
   localparam int unsigned IMM_W = 2;

   localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_ITYPE  = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

   // 2'b11 is reserved and never produced by the decoder
   typedef enum logic [IMM_W-1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10
   } imm_sel_e;

   typedef struct packed {
      logic     pcsrc;
      logic     enw;
      imm_sel_e immsel;
      logic     alusrc;
      logic     ramw;
      logic     wb;
      logic     ramr;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{
      pcsrc: 1'b0, enw: 1'b0, immsel: IMM_I, alusrc: 1'b0,
      ramw: 1'b0, wb: 1'b0, ramr: 1'b0
   };

endpackage : control_pkg

// File: rtl/control_if.sv
// Decoder-to-datapath bundle: instruction opcode and ALU zero flag in,
// registered control strobes out.
interface control_if;
   import control_pkg::*;

   logic [OPC_W-1:0] OPCode;
   logic             Zero;
   logic             PCsrc;
   logic             EnW;
   logic [IMM_W-1:0] IMMSel;
   logic             ALUsrc;
   logic             RAMW;
   logic             WB;
   logic             RAMR;

   modport master (
      output OPCode, Zero,
      input  PCsrc, EnW, IMMSel, ALUsrc, RAMW, WB, RAMR
   );

   modport slave (
      input  OPCode, Zero,
      output PCsrc, EnW, IMMSel, ALUsrc, RAMW, WB, RAMR
   );

endinterface : control_if

// File: rtl/control_decode.sv
// Combinational opcode/Zero to control-vector decode; unknown opcodes
// decode to an all-zero NOP vector.
module control_decode
   import control_pkg::*;
(
   input  logic [OPC_W-1:0] opcode_i,
   input  logic             zero_i,
   output ctrl_t            ctrl_c_o
);

   always_comb begin
      ctrl_c_o = CTRL_NOP;
      case (opcode_i)
         OP_RTYPE: begin
            ctrl_c_o.enw = 1'b1;
         end
         OP_ITYPE: begin
            ctrl_c_o.enw    = 1'b1;
            ctrl_c_o.alusrc = 1'b1;
         end
         OP_LOAD: begin
            ctrl_c_o.enw    = 1'b1;
            ctrl_c_o.alusrc = 1'b1;
            ctrl_c_o.wb     = 1'b1;
            ctrl_c_o.ramr   = 1'b1;
         end
         OP_STORE: begin
            ctrl_c_o.immsel = IMM_S;
            ctrl_c_o.alusrc = 1'b1;
            ctrl_c_o.ramw   = 1'b1;
         end
         // BEQ: branch taken only when the ALU compare says equal
         OP_BRANCH: begin
            ctrl_c_o.pcsrc  = zero_i;
            ctrl_c_o.immsel = IMM_B;
         end
         default: ;
      endcase
   end

endmodule : control_decode

// File: rtl/control.sv
// RV32I main decoder: combinational decode followed by one output register
// cleared by synchronous reset.
module control
   import control_pkg::*;
(
   input  logic      clk,
   input logic       reset,
   control_if.slave  ctl
);

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   control_decode u_decode (
      .opcode_i (ctl.OPCode),
      .zero_i   (ctl.Zero),
      .ctrl_c_o (ctrl_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q <= CTRL_NOP;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign ctl.PCsrc  = ctrl_q.pcsrc;
   assign ctl.EnW    = ctrl_q.enw;
   assign ctl.IMMSel = IMM_W'(ctrl_q.immsel);
   assign ctl.ALUsrc = ctrl_q.alusrc;
   assign ctl.RAMW   = ctrl_q.ramw;
   assign ctl.WB     = ctrl_q.wb;
   assign ctl.RAMR   = ctrl_q.ramr;

endmodule : control

// File: tb/tb_control.sv
// Self-checking bench for the main decoder: directed test-plan sequence then
// randomized opcode/Zero/reset traffic against a table-driven model.
module tb_control;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   control_if ctl ();

   control dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (ctl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Expected {PCsrc,EnW,IMMSel[1:0],ALUsrc,RAMW,WB,RAMR} straight from the opcode table
   function automatic logic [7:0] model(input logic [6:0] op, input logic z, input logic rst);
      logic [7:0] v;
      v = 8'h00;
      if (rst)                   v = 8'b0_0_00_0_0_0_0;
      else if (op == 7'b0110011) v = 8'b0_1_00_0_0_0_0;
      else if (op == 7'b0010011) v = 8'b0_1_00_1_0_0_0;
      else if (op == 7'b0000011) v = 8'b0_1_00_1_0_1_1;
      else if (op == 7'b0100011) v = 8'b0_0_01_1_1_0_0;
      else if (op == 7'b1100011) v = {z, 7'b0_10_0_0_0_0};
      return v;
   endfunction

   function automatic logic [7:0] observed();
      return {ctl.PCsrc, ctl.EnW, ctl.IMMSel, ctl.ALUsrc, ctl.RAMW, ctl.WB, ctl.RAMR};
   endfunction

   // Apply inputs, take one edge, compare the registered result just after it
   task automatic step(input string tag, input logic [6:0] op, input logic z, input logic rst);
      logic [7:0] obs;
      ctl.OPCode = op;
      ctl.Zero   = z;
      reset      = rst;
      @(posedge clk);
      #1;
      obs = observed();
      check_val(tag, obs, model(op, z, rst));
      check_val({tag, "_ramw_ramr"}, 8'(obs[2] & obs[0]), 8'h00);
      check_val({tag, "_enw_ramw"},  8'(obs[6] & obs[2]), 8'h00);
   endtask

   initial begin
      logic [6:0] op;
      logic       z;
      logic       r;
      n_tests    = 0;
      n_fail     = 0;
      reset      = 1'b1;
      ctl.OPCode = 7'b0110011;
      ctl.Zero   = 1'b0;

      step("reset0", 7'b0110011, 1'b0, 1'b1);
      step("reset1", 7'b0110011, 1'b0, 1'b1);
      step("release_r", 7'b0110011, 1'b0, 1'b0);

      step("rtype",  7'b0110011, 1'b0, 1'b0);
      step("itype",  7'b0010011, 1'b0, 1'b0);
      step("store",  7'b0100011, 1'b0, 1'b0);
      step("load",   7'b0000011, 1'b0, 1'b0);

      step("br_nt",      7'b1100011, 1'b0, 1'b0);
      step("br_t",       7'b1100011, 1'b1, 1'b0);
      step("br_toggle",  7'b1100011, 1'b0, 1'b0);
      step("br_t2",      7'b1100011, 1'b1, 1'b0);

      step("zero_rtype", 7'b0110011, 1'b1, 1'b0);
      step("zero_load",  7'b0000011, 1'b1, 1'b0);
      step("zero_store", 7'b0100011, 1'b1, 1'b0);

      step("nop00", 7'b0000000, 1'b0, 1'b0);
      step("nop7f", 7'b1111111, 1'b1, 1'b0);

      step("load_pre", 7'b0000011, 1'b0, 1'b0);
      step("load_rst", 7'b0000011, 1'b0, 1'b1);
      step("load_rel", 7'b0000011, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 7))
            0:       op = 7'b0110011;
            1:       op = 7'b0010011;
            2:       op = 7'b0000011;
            3:       op = 7'b0100011;
            4, 5:    op = 7'b1100011;
            default: op = 7'($urandom);
         endcase
         z = 1'($urandom);
         r = ($urandom_range(0, 19) == 0);
         step("rand", op, z, r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_control
